// File: rtl/mm_feeder_if.sv
// Streaming link between the feeder and the matrix-multiply engine.
// The feeder drives elements and end flags; the engine returns results and verdicts.
interface mm_feeder_if #(
  parameter int DW = 8,
  parameter int RW = 20
);
  logic signed [DW-1:0] mm_in_data;
  logic                 mm_col_end;
  logic                 mm_row_end;
  logic                 mm_busy;
  logic                 mm_valid;
  logic signed [RW-1:0] mm_out_data;
  logic                 mm_is_legal;
  logic                 mm_change_row;

  modport master (
    output mm_in_data, mm_col_end, mm_row_end,
    input  mm_busy, mm_valid, mm_out_data, mm_is_legal, mm_change_row
  );

  modport slave (
    input  mm_in_data, mm_col_end, mm_row_end,
    output mm_busy, mm_valid, mm_out_data, mm_is_legal, mm_change_row
  );
endinterface

// File: rtl/mm_feeder.sv
// Loads A/B stores, streams A then B one element per cycle from the cycle after start, collects results.
// No stream backpressure; start is dropped while the engine is busy, WAIT aborts after TIMEOUT idle cycles.
module mm_feeder #(
  parameter int DW      = 8,
  parameter int RW      = 20,
  parameter int MAXD    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [3:0]           cfg_addr,
  input  logic signed [DW-1:0] cfg_data,
  input  logic [2:0]           a_rows,
  input  logic [2:0]           a_cols,
  input  logic [2:0]           b_rows,
  input  logic [2:0]           b_cols,
  input  logic                 start,
  mm_feeder_if.master          mm,
  input  logic [3:0]           res_raddr,
  output logic signed [RW-1:0] res_rdata,
  output logic [4:0]           res_cnt,
  output logic                 done,
  output logic                 legal,
  output logic                 err
);
  localparam int DEPTH = MAXD * MAXD;
  localparam int WDW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, FIN} state_t;

  state_t state, state_n;
  logic [2:0] r, c, r_n, c_n, nr, nc, rows, cols;
  logic [2:0] ar, ac, br, bc, ar_n, ac_n, br_n, bc_n;
  logic [2:0] row_cnt, row_n;
  logic [WDW-1:0] wdog, wdog_n;
  logic [4:0] cnt_n, target;
  logic signed [DW-1:0] in_data, in_n;
  logic col_end, row_end, ce_n, re_n;
  logic err_n, legal_n, done_n, res_we, last_c, last_r;

  logic signed [DW-1:0] a_mem [DEPTH];
  logic signed [DW-1:0] b_mem [DEPTH];
  logic signed [RW-1:0] res_mem [DEPTH];

  function automatic logic bad_dim(input logic [2:0] d);
    return (d == 3'd0) || (d > 3'(MAXD));
  endfunction

  function automatic logic [3:0] ix(input logic [2:0] rr, input logic [2:0] cc, input logic [2:0] nn);
    return 4'(rr) * 4'(nn) + 4'(cc);
  endfunction

  assign rows   = (state == SEND_B) ? br : ar;
  assign cols   = (state == SEND_B) ? bc : ac;
  assign last_c = (c == cols - 3'd1);
  assign last_r = (r == rows - 3'd1);
  assign nc     = last_c ? 3'd0 : c + 3'd1;
  assign nr     = last_c ? r + 3'd1 : r;
  assign target = 5'(ar) * 5'(bc);
  assign done_n = (state_n == FIN);

  always_comb begin
    state_n = state;
    r_n = r;   c_n = c;
    ar_n = ar; ac_n = ac; br_n = br; bc_n = bc;
    in_n = '0; ce_n = 1'b0; re_n = 1'b0;
    cnt_n = res_cnt; err_n = err; legal_n = legal;
    row_n = row_cnt; wdog_n = wdog; res_we = 1'b0;
    case (state)
      IDLE: begin
        if (start && !mm.mm_busy) begin
          cnt_n = '0; err_n = 1'b0; legal_n = 1'b0; row_n = '0; wdog_n = '0;
          r_n = '0; c_n = '0;
          ar_n = a_rows; ac_n = a_cols; br_n = b_rows; bc_n = b_cols;
          if (bad_dim(a_rows) || bad_dim(a_cols) || bad_dim(b_rows) || bad_dim(b_cols)) begin
            err_n   = 1'b1;
            state_n = FIN;
          end else begin
            state_n = SEND_A;
            in_n    = a_mem[0];
            ce_n    = (a_cols == 3'd1);
            re_n    = (a_cols == 3'd1) && (a_rows == 3'd1);
          end
        end
      end
      SEND_A, SEND_B: begin
        if (last_c && last_r) begin
          r_n = '0; c_n = '0;
          // B[0] follows A's last element with no gap
          if (state == SEND_A) begin
            state_n = SEND_B;
            in_n    = b_mem[0];
            ce_n    = (bc == 3'd1);
            re_n    = (bc == 3'd1) && (br == 3'd1);
          end else begin
            state_n = WAIT;
            wdog_n  = '0;
          end
        end else begin
          r_n  = nr;
          c_n  = nc;
          in_n = (state == SEND_A) ? a_mem[ix(nr, nc, cols)] : b_mem[ix(nr, nc, cols)];
          ce_n = (nc == cols - 3'd1);
          re_n = ce_n && (nr == rows - 3'd1);
        end
      end
      WAIT: begin
        if (mm.mm_valid) begin
          wdog_n = '0;
          if (mm.mm_is_legal) begin
            legal_n = 1'b1;
            if (ac != br) err_n = 1'b1;
            if (res_cnt < 5'(DEPTH)) begin
              res_we = 1'b1;
              cnt_n  = res_cnt + 5'd1;
            end
            if (cnt_n == target) state_n = FIN;
          end else begin
            legal_n = 1'b0;
            if (ac == br) err_n = 1'b1;
            state_n = FIN;
          end
        end else if (wdog == WDW'(TIMEOUT)) begin
          err_n   = 1'b1;
          state_n = FIN;
        end else begin
          wdog_n = wdog + 1'b1;
        end
        if (mm.mm_change_row) begin
          if (row_cnt != 3'd7) row_n = row_cnt + 3'd1;
          if ({1'b0, row_cnt} + 4'd1 > {1'b0, ar}) err_n = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r <= '0; c <= '0;
      ar <= '0; ac <= '0; br <= '0; bc <= '0;
      in_data <= '0; col_end <= 1'b0; row_end <= 1'b0;
      res_cnt <= '0; err <= 1'b0; legal <= 1'b0; done <= 1'b0;
      row_cnt <= '0; wdog <= '0;
    end else begin
      state <= state_n;
      r <= r_n; c <= c_n;
      ar <= ar_n; ac <= ac_n; br <= br_n; bc <= bc_n;
      in_data <= in_n; col_end <= ce_n; row_end <= re_n;
      res_cnt <= cnt_n; err <= err_n; legal <= legal_n; done <= done_n;
      row_cnt <= row_n; wdog <= wdog_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      if (cfg_sel) b_mem[cfg_addr] <= cfg_data;
      else         a_mem[cfg_addr] <= cfg_data;
    end
    if (res_we) res_mem[res_cnt[3:0]] <= mm.mm_out_data;
  end

  assign mm.mm_in_data = in_data;
  assign mm.mm_col_end = col_end;
  assign mm.mm_row_end = row_end;
  assign res_rdata     = res_mem[res_raddr];
endmodule

// File: tb/tb_mm_feeder.sv
// Directed bench for mm_feeder: table of whole jobs plus hand sequences for busy-drop and mid-stream reset.
module tb_mm_feeder;
  localparam int DW = 8, RW = 20, MAXD = 4, TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [3:0]           cfg_addr = '0;
  logic signed [DW-1:0] cfg_data = '0;
  logic [2:0]           a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic                 start = 1'b0;
  logic [3:0]           res_raddr = '0;
  logic signed [RW-1:0] res_rdata;
  logic [4:0]           res_cnt;
  logic                 done, legal, err;

  mm_feeder_if #(.DW(DW), .RW(RW)) mmif();

  mm_feeder #(.DW(DW), .RW(RW), .MAXD(MAXD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .start(start), .mm(mmif),
    .res_raddr(res_raddr), .res_rdata(res_rdata), .res_cnt(res_cnt),
    .done(done), .legal(legal), .err(err)
  );

  // mode: 0 engine returns results, 1 engine says illegal, 2 engine silent, 3 bad dimensions
  typedef struct {
    logic [2:0]        ar, ac, br, bc;
    logic signed [7:0] a0, b0;
    int                mode;
    int                nres;
    logic [3:0][19:0]  res;
    logic [15:0]       col_mask, row_mask;
    logic [4:0]        e_cnt;
    logic              e_legal, e_err;
  } vec_t;

  vec_t tbl [6];
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic load_stores(input int na, input int nb, input logic signed [7:0] a0, input logic signed [7:0] b0);
    for (int i = 0; i < na + nb; i++) begin
      cfg_we   = 1'b1;
      cfg_sel  = (i >= na);
      cfg_addr = (i < na) ? 4'(i) : 4'(i - na);
      cfg_data = (i < na) ? a0 + 8'(i) : b0 + 8'(i - na);
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic run_job(input int id, input vec_t v);
    int na, nb, n, k;
    logic [15:0] gc, gr;
    logic signed [7:0] e;
    na = int'(v.ar) * int'(v.ac);
    nb = int'(v.br) * int'(v.bc);
    n  = (v.mode == 3) ? 0 : na + nb;
    load_stores(na, nb, v.a0, v.b0);
    a_rows = v.ar; a_cols = v.ac; b_rows = v.br; b_cols = v.bc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; gc = '0; gr = '0;
    for (int i = 0; i < n; i++) begin
      e = (i < na) ? v.a0 + 8'(i) : v.b0 + 8'(i - na);
      chk($sformatf("job%0d_data%0d", id, i), mmif.mm_in_data, e);
      gc[i] = mmif.mm_col_end;
      gr[i] = mmif.mm_row_end;
      @(negedge clk);
      k++;
    end
    chk($sformatf("job%0d_col_mask", id), gc, v.col_mask);
    chk($sformatf("job%0d_row_mask", id), gr, v.row_mask);
    chk($sformatf("job%0d_quiet_after", id), {mmif.mm_in_data, mmif.mm_col_end, mmif.mm_row_end}, 0);
    if (v.mode == 0) begin
      for (int i = 0; i < v.nres; i++) begin
        mmif.mm_valid      = 1'b1;
        mmif.mm_is_legal   = 1'b1;
        mmif.mm_out_data   = v.res[i];
        mmif.mm_change_row = ((i + 1) % int'(v.bc) == 0);
        @(negedge clk);
        k++;
      end
    end else if (v.mode == 1) begin
      mmif.mm_valid    = 1'b1;
      mmif.mm_is_legal = 1'b0;
      @(negedge clk);
      k++;
    end
    mmif.mm_valid = 1'b0; mmif.mm_is_legal = 1'b0;
    mmif.mm_change_row = 1'b0; mmif.mm_out_data = '0;
    while (!done && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("job%0d_done_seen", id), done, 1);
    // silent engine: TIMEOUT+1 WAIT cycles, then the FIN cycle
    if (v.mode == 2) chk($sformatf("job%0d_timeout_latency", id), k, n + TIMEOUT + 2);
    if (v.mode == 3) chk($sformatf("job%0d_baddim_latency", id), k, 1);
    chk($sformatf("job%0d_res_cnt", id), res_cnt, v.e_cnt);
    chk($sformatf("job%0d_legal", id), legal, v.e_legal);
    chk($sformatf("job%0d_err", id), err, v.e_err);
    @(negedge clk);
    chk($sformatf("job%0d_done_one_cycle", id), done, 0);
    chk($sformatf("job%0d_res_cnt_hold", id), res_cnt, v.e_cnt);
    for (int i = 0; i < v.nres; i++) begin
      res_raddr = 4'(i);
      #1;
      chk($sformatf("job%0d_res%0d", id, i), res_rdata, v.res[i]);
    end
  endtask

  initial begin
    tbl[0] = '{3'd2, 3'd3, 3'd3, 3'd2, 8'sd1, 8'sd7, 0, 4,
               {20'sd154, 20'sd139, 20'sd64, 20'sd58}, 16'h0AA4, 16'h0820, 5'd4, 1'b1, 1'b0};
    tbl[1] = '{3'd2, 3'd3, 3'd2, 3'd3, 8'sd1, 8'sd7, 1, 0,
               {20'sd0, 20'sd0, 20'sd0, 20'sd0}, 16'h0924, 16'h0820, 5'd0, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 3'd2, 3'd2, 3'd2, 8'sd1, 8'sd5, 1, 0,
               {20'sd0, 20'sd0, 20'sd0, 20'sd0}, 16'h00AA, 16'h0088, 5'd0, 1'b0, 1'b1};
    tbl[3] = '{3'd1, 3'd1, 3'd1, 3'd1, 8'h80, 8'h80, 0, 1,
               {20'sd0, 20'sd0, 20'sd0, 20'sd16384}, 16'h0003, 16'h0003, 5'd1, 1'b1, 1'b0};
    tbl[4] = '{3'd2, 3'd2, 3'd2, 3'd2, 8'sd3, 8'sd9, 2, 0,
               {20'sd0, 20'sd0, 20'sd0, 20'sd0}, 16'h00AA, 16'h0088, 5'd0, 1'b0, 1'b1};
    tbl[5] = '{3'd0, 3'd2, 3'd2, 3'd2, 8'sd1, 8'sd5, 3, 0,
               {20'sd0, 20'sd0, 20'sd0, 20'sd0}, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};

    mmif.mm_busy = 1'b0; mmif.mm_valid = 1'b0; mmif.mm_out_data = '0;
    mmif.mm_is_legal = 1'b0; mmif.mm_change_row = 1'b0;

    @(negedge clk);
    chk("rst_stream", {mmif.mm_in_data, mmif.mm_col_end, mmif.mm_row_end}, 0);
    chk("rst_flags", {done, legal, err}, 0);
    chk("rst_res_cnt", res_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    load_stores(1, 1, 8'sd5, 8'sd6);
    mmif.mm_busy = 1'b1;
    a_rows = 3'd1; a_cols = 3'd1; b_rows = 3'd1; b_cols = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_drop_quiet%0d", i),
          {mmif.mm_in_data, mmif.mm_col_end, mmif.mm_row_end, done}, 0);
      @(negedge clk);
    end
    mmif.mm_busy = 1'b0;

    for (int j = 0; j < 6; j++) run_job(j, tbl[j]);

    load_stores(4, 4, 8'sd1, 8'sd5);
    a_rows = 3'd2; a_cols = 3'd2; b_rows = 3'd2; b_cols = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_col_end", mmif.mm_col_end, 1);
    chk("pre_rst_data", mmif.mm_in_data, 6);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_stream", {mmif.mm_in_data, mmif.mm_col_end, mmif.mm_row_end}, 0);
    chk("async_rst_flags", {done, legal, err, res_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {mmif.mm_in_data, mmif.mm_col_end, mmif.mm_row_end, done}, 0);
    run_job(6, tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
